// File: rtl/i2c_temp_reader.sv
// ============================================================================
// i2c_temp_reader
//
// Purpose:
//   I2C master that reads the 2-byte temperature register of an LM75-class
//   sensor and presents it as data[15:0] ({MSB, LSB}). It performs one read
//   for each accepted start request. The bus is open-drain, so the block only
//   ever pulls SDA low.
//
// Optional feature (macro POINTER_WRITE_EN):
//   When defined, the read is preceded by a pointer write:
//   START, {DEV_ADDR,0}, ACK, 0x00, ACK, then a repeated START into the normal
//   read sequence. When undefined, the block relies on the sensor's power-up
//   pointer value of 0 and performs a read-only sequence.
//
// Ports:
//   clk         in   system clock, all logic on the rising edge
//   rst         in   synchronous reset, active-high
//   start       in   one-cycle request to begin a read (ignored while busy)
//   sda_i       in   sampled SDA line (pulled up externally)
//   sda_oe      out  1 = pull SDA low, 0 = release
//   scl         out  SCL drive (1 = released/high)
//   busy        out  high from accepted start until STOP completes
//   data        out  last good reading {MSB, LSB}
//   data_valid  out  one-cycle pulse when data updates
//   ack_err     out  one-cycle pulse when the slave NACKs an address/write byte
// ============================================================================
module i2c_temp_reader #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned I2C_FREQ = 100_000,
    parameter logic [6:0]  DEV_ADDR = 7'h48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        scl,
    output logic        busy,
    output logic [15:0] data,
    output logic        data_valid,
    output logic        ack_err
);

    localparam int unsigned Q  = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned DW = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(Q - 1);
    localparam logic [7:0] RD_BYTE = {DEV_ADDR, 1'b1};
`ifdef POINTER_WRITE_EN
    localparam logic [7:0] WR_BYTE  = {DEV_ADDR, 1'b0};
    localparam logic [7:0] PTR_BYTE = 8'h00;
`endif

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        AACK,
        RD_MSB,
        MACK,
        RD_LSB,
        MNACK,
        STOP
    } state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    msb;
    logic          got_data;
    logic          nack;
`ifdef POINTER_WRITE_EN
    logic [1:0]    tx_idx;
`endif
    logic          tick;

    // A quarter-bit tick fires once every Q clocks while a transfer is active.
    assign tick = (div_cnt == DIV_LAST);

    // Single sequencer for the whole transfer. Each tick executes the action
    // of the current quarter-bit phase and then advances the phase:
    //   phase 0 drops SCL and presents the next SDA value,
    //   phase 1 raises SCL, phase 2 samples SDA, phase 3 drops SCL again.
    // START and STOP reuse the same four-phase frame so that the SDA edges
    // land while SCL is high. The transmit byte (address, and in pointer mode
    // also the write address and pointer) travels through shreg MSB first;
    // received bytes are shifted into the same register. The LSB is left in
    // shreg until the final STOP tick, where the complete word is published
    // together with the data_valid pulse and the fall of busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            phase      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            msb        <= '0;
            got_data   <= 1'b0;
            nack       <= 1'b0;
            sda_oe     <= 1'b0;
            scl        <= 1'b1;
            busy       <= 1'b0;
            data       <= 16'h0000;
            data_valid <= 1'b0;
            ack_err    <= 1'b0;
`ifdef POINTER_WRITE_EN
            tx_idx     <= 2'd0;
`endif
        end else begin
            data_valid <= 1'b0;
            ack_err    <= 1'b0;
            if (state == IDLE) begin
                div_cnt <= '0;
                phase   <= '0;
                if (start) begin
                    state    <= START;
                    busy     <= 1'b1;
                    got_data <= 1'b0;
`ifdef POINTER_WRITE_EN
                    tx_idx   <= 2'd0;
`endif
                end
            end else if (!tick) begin
                div_cnt <= div_cnt + DW'(1);
            end else begin
                div_cnt <= '0;
                phase   <= phase + 2'd1;
                case (state)
                    START: begin
                        case (phase)
                            2'd0: begin
                                scl    <= 1'b1;
                                sda_oe <= 1'b0;
                            end
                            2'd1: sda_oe <= 1'b1;
                            2'd2: ;
                            2'd3: begin
                                scl     <= 1'b0;
                                bit_cnt <= 3'd7;
                                state   <= ADDR;
`ifdef POINTER_WRITE_EN
                                shreg   <= (tx_idx == 2'd0) ? WR_BYTE : RD_BYTE;
`else
                                shreg   <= RD_BYTE;
`endif
                            end
                        endcase
                    end
                    ADDR: begin
                        case (phase)
                            2'd0: begin
                                scl    <= 1'b0;
                                sda_oe <= ~shreg[7];
                            end
                            2'd1: scl <= 1'b1;
                            2'd2: ;
                            2'd3: begin
                                scl     <= 1'b0;
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= bit_cnt - 3'd1;
                                if (bit_cnt == 3'd0) begin
                                    state <= AACK;
                                end
                            end
                        endcase
                    end
                    AACK, MACK, MNACK: begin
                        case (phase)
                            2'd0: begin
                                scl    <= 1'b0;
                                sda_oe <= (state == MACK);
                            end
                            2'd1: scl <= 1'b1;
                            2'd2: nack <= sda_i;
                            2'd3: begin
                                scl <= 1'b0;
                                if (state == MACK) begin
                                    state   <= RD_LSB;
                                    bit_cnt <= 3'd7;
                                end else if (state == MNACK) begin
                                    state <= STOP;
                                end else if (nack) begin
                                    ack_err <= 1'b1;
                                    state   <= STOP;
                                end
`ifdef POINTER_WRITE_EN
                                else if (tx_idx == 2'd0) begin
                                    tx_idx  <= 2'd1;
                                    shreg   <= PTR_BYTE;
                                    bit_cnt <= 3'd7;
                                    state   <= ADDR;
                                end else if (tx_idx == 2'd1) begin
                                    tx_idx <= 2'd2;
                                    state  <= START;
                                end
`endif
                                else begin
                                    state   <= RD_MSB;
                                    bit_cnt <= 3'd7;
                                end
                            end
                        endcase
                    end
                    RD_MSB, RD_LSB: begin
                        case (phase)
                            2'd0: begin
                                scl    <= 1'b0;
                                sda_oe <= 1'b0;
                            end
                            2'd1: scl <= 1'b1;
                            2'd2: shreg <= {shreg[6:0], sda_i};
                            2'd3: begin
                                scl     <= 1'b0;
                                bit_cnt <= bit_cnt - 3'd1;
                                if (bit_cnt == 3'd0) begin
                                    if (state == RD_MSB) begin
                                        msb   <= shreg;
                                        state <= MACK;
                                    end else begin
                                        got_data <= 1'b1;
                                        state    <= MNACK;
                                    end
                                end
                            end
                        endcase
                    end
                    STOP: begin
                        case (phase)
                            2'd0: begin
                                scl    <= 1'b0;
                                sda_oe <= 1'b1;
                            end
                            2'd1: scl <= 1'b1;
                            2'd2: ;
                            2'd3: begin
                                sda_oe <= 1'b0;
                                busy   <= 1'b0;
                                state  <= IDLE;
                                if (got_data) begin
                                    data       <= {msb, shreg};
                                    data_valid <= 1'b1;
                                end
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
